intr_ctl: RTL
=============

INTR_CTL -- requirements
Module: intr_ctl

Interface
REQ-001 Parameter RV, default 16: io data width in bits.
REQ-002 Parameter NSRC, default 8: number of interrupt sources, 1..RV-1.
REQ-003 Parameter IDW, default $clog2(NSRC): claim id width.
REQ-004 clk  input  1  sole clock, all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 irq_src  input  NSRC  raw source requests, bit i = source i.
REQ-007 io_addr  input  4  register word index.
REQ-008 io_write  input  1  single-cycle write strobe.
REQ-009 io_read  input  1  single-cycle read strobe, side-effect qualifier.
REQ-010 io_wdata  input  RV  write data.
REQ-011 io_rdata  output  RV  combinational read data for io_addr.
REQ-012 interrupt  output  1  registered CPU interrupt request.

Function
REQ-013 Per-source state: IDLE, PEND, INSVC (in service); INSVC also carries a latched re-pend flag.
REQ-014 Sampled source s[i] = irq_src[i], or the synchronised value when INTR_SYNC_EN is set; s_prev[i] = s[i] delayed one clock.
REQ-015 Edge mode (MODE[i]=1): s & ~s_prev moves IDLE->PEND; in INSVC it sets re-pend instead.
REQ-016 Level mode (MODE[i]=0): IDLE->PEND while s[i]=1; PEND->IDLE when s[i]=0.
REQ-017 Register 0 PENDING: read = PEND bits; write-1-to-clear of edge sources PEND->IDLE; a set event in the same cycle wins; no effect on level sources.
REQ-018 Register 1 ENABLE: read/write, NSRC bits.
REQ-019 Register 2 MODE: read/write, NSRC bits.
REQ-020 Register 3 CLAIM: read = {valid at bit RV-1, id in [IDW-1:0]}, id = lowest index with PEND & ENABLE.
REQ-021 CLAIM read with io_read=1 and valid=1: the claimed source goes PEND->INSVC on that edge.
REQ-022 CLAIM read with valid=0 returns 0 and has no side effect.
REQ-023 CLAIM write (complete) of id in INSVC: goes to PEND if re-pend is set, or if level mode with s=1; otherwise to IDLE.
REQ-024 CLAIM write of id not in INSVC, or id>=NSRC, is ignored.
REQ-025 Register 4 CTRL: bit0 = global enable (GIE).
REQ-026 All other addresses read 0; writes to them are ignored.
REQ-027 interrupt is registered = GIE & |(PEND & ENABLE), one clock after the state update.
REQ-028 Latency from irq_src rising (setup met before edge E0) to interrupt high: E1 without the macro, E3 with it.
REQ-029 Unused io_wdata and io_rdata bits: writes ignored, reads return 0.

Reset
REQ-030 On reset assertion, immediately: all sources IDLE, re-pend flags cleared, ENABLE=0, MODE=0, GIE=0, interrupt=0, s_prev=0, synchronisers=0.
REQ-031 Reset during an outstanding claim discards INSVC state; no completion is required afterwards.

Configuration
REQ-032 Macro INTR_SYNC_EN defined: a two-flop synchroniser precedes the edge/level logic on each irq_src bit, adding 2 clocks of latency.
REQ-033 INTR_SYNC_EN undefined: irq_src is used directly; the sources must be synchronous to clk.

Structure
REQ-034 Package intr_ctl_pkg holds: register indices (PENDING=0, ENABLE=1, MODE=2, CLAIM=3, CTRL=4), the claim-valid bit position, and the source-state enum.
REQ-035 Sub-module intr_src_sync holds the per-source synchroniser (macro-controlled) and the s_prev edge register; it is instantiated NSRC times.

Verification
REQ-036 Edge: MODE=0x01, ENABLE=0x01, GIE=1; pulse irq_src[0] one cycle -> PENDING=0x0001, interrupt=1 at E1 (E3 with INTR_SYNC_EN).
REQ-037 Priority/claim: sources 2 and 5 pending and enabled -> CLAIM reads 0x8002; second CLAIM reads 0x8005; third CLAIM reads 0x0000; interrupt then 0.
REQ-038 Re-pend: claim edge source 3, pulse it again while INSVC, write CLAIM=3 -> source 3 is PEND and interrupt reasserts the next clock.
REQ-039 Level: MODE=0, irq_src[1] held high; claim, then complete -> PEND again; drop irq_src[1], complete again -> IDLE, interrupt=0.
REQ-040 Collision: W1C PENDING=0x0004 in the same cycle as an edge on source 2 -> PENDING stays 0x0004.
REQ-041 Mid-claim reset: assert reset with source 0 INSVC -> all registers 0 and interrupt=0 immediately; CLAIM reads 0 after release.

Source files
------------

// File: rtl/intr_ctl_pkg.sv
// Shared definitions for the interrupt controller: register map, claim
// word layout and the per-source state encoding.
package intr_ctl_pkg;

    localparam logic [3:0] REG_PENDING = 4'd0;
    localparam logic [3:0] REG_ENABLE  = 4'd1;
    localparam logic [3:0] REG_MODE    = 4'd2;
    localparam logic [3:0] REG_CLAIM   = 4'd3;
    localparam logic [3:0] REG_CTRL    = 4'd4;

    localparam int CTRL_GIE_BIT = 0;

    typedef enum logic [1:0] {
        SRC_IDLE  = 2'd0,
        SRC_PEND  = 2'd1,
        SRC_INSVC = 2'd2
    } src_state_e;

    // The valid flag sits in the top bit of the claim word, whatever the bus width.
    function automatic int claim_valid_bit(input int rv);
        return rv - 1;
    endfunction

endpackage

// File: rtl/intr_src_sync.sv
// Per-source input conditioning: optional two-flop synchroniser (INTR_SYNC_EN)
// followed by the one-clock delay register used for edge detection.
module intr_src_sync (
    input  logic clk,
    input  logic reset,
    input  logic irq_raw,
    output logic s,
    output logic s_prev
);

`ifdef INTR_SYNC_EN
    logic sync_meta;
    logic sync_out;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_meta <= 1'b0;
            sync_out  <= 1'b0;
        end else begin
            sync_meta <= irq_raw;
            sync_out  <= sync_meta;
        end
    end

    assign s = sync_out;
`else
    // Sources are already synchronous to clk in this build.
    assign s = irq_raw;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s_prev <= 1'b0;
        end else begin
            s_prev <= s;
        end
    end

endmodule

// File: rtl/intr_ctl.sv
// Interrupt controller: per-source edge/level capture, enable/mode registers,
// lowest-index claim/complete protocol and a registered CPU interrupt.
// Build option: INTR_SYNC_EN adds a two-flop synchroniser per source.
//
// Per-source state:
//   state     | meaning
//   SRC_IDLE  | no request outstanding
//   SRC_PEND  | request captured, visible in PENDING and eligible for claim
//   SRC_INSVC | claimed by the CPU; repend_q records an edge seen meanwhile
module intr_ctl
    import intr_ctl_pkg::*;
#(
    parameter int RV   = 16,
    parameter int NSRC = 8,
    parameter int IDW  = $clog2(NSRC)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NSRC-1:0] irq_src,
    input  logic [3:0]      io_addr,
    input  logic            io_write,
    input  logic            io_read,
    input  logic [RV-1:0]   io_wdata,
    output logic [RV-1:0]   io_rdata,
    output logic            interrupt
);

    localparam int VALID_BIT = claim_valid_bit(RV);

    logic [NSRC-1:0] s;
    logic [NSRC-1:0] s_prev;
    logic [NSRC-1:0] edge_ev;
    logic [NSRC-1:0] pend_vec;
    logic [NSRC-1:0] enable_q;
    logic [NSRC-1:0] mode_q;
    logic [NSRC-1:0] repend_q;
    logic [NSRC-1:0] repend_d;
    logic            gie_q;

    src_state_e      state_q [NSRC];
    src_state_e      state_d [NSRC];

    logic            claim_valid;
    logic [IDW-1:0]  claim_id;
    logic [IDW-1:0]  done_id;

    logic            wr_pending;
    logic            wr_enable;
    logic            wr_mode;
    logic            wr_claim;
    logic            wr_ctrl;
    logic            claim_take;

    logic            wdata_unused;

    for (genvar g = 0; g < NSRC; g++) begin : g_src
        intr_src_sync u_sync (
            .clk     (clk),
            .reset   (reset),
            .irq_raw (irq_src[g]),
            .s       (s[g]),
            .s_prev  (s_prev[g])
        );
    end

    assign edge_ev      = s & ~s_prev;
    assign done_id      = io_wdata[IDW-1:0];
    assign wdata_unused = ^io_wdata[RV-1:NSRC];

    assign wr_pending = io_write && (io_addr == REG_PENDING);
    assign wr_enable  = io_write && (io_addr == REG_ENABLE);
    assign wr_mode    = io_write && (io_addr == REG_MODE);
    assign wr_claim   = io_write && (io_addr == REG_CLAIM);
    assign wr_ctrl    = io_write && (io_addr == REG_CTRL);
    assign claim_take = io_read && (io_addr == REG_CLAIM) && claim_valid;

    always_comb begin
        for (int i = 0; i < NSRC; i++) begin
            pend_vec[i] = (state_q[i] == SRC_PEND);
        end
    end

    // Descending scan so the lowest eligible index is the one left standing.
    always_comb begin
        claim_valid = 1'b0;
        claim_id    = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (pend_vec[i] && enable_q[i]) begin
                claim_valid = 1'b1;
                claim_id    = IDW'(i);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NSRC; i++) begin
            state_d[i]  = state_q[i];
            repend_d[i] = repend_q[i];
            case (state_q[i])
                SRC_IDLE: begin
                    if (mode_q[i] ? edge_ev[i] : s[i]) begin
                        state_d[i] = SRC_PEND;
                    end
                end
                SRC_PEND: begin
                    // A claim already handed this id to the CPU, so it takes
                    // precedence over a level drop or a W1C in the same cycle.
                    if (claim_take && (claim_id == IDW'(i))) begin
                        state_d[i]  = SRC_INSVC;
                        repend_d[i] = 1'b0;
                    end else if (!mode_q[i] && !s[i]) begin
                        state_d[i] = SRC_IDLE;
                    end else if (mode_q[i] && wr_pending && io_wdata[i] && !edge_ev[i]) begin
                        state_d[i] = SRC_IDLE;
                    end
                end
                SRC_INSVC: begin
                    if (mode_q[i] && edge_ev[i]) begin
                        repend_d[i] = 1'b1;
                    end
                    if (wr_claim && (done_id == IDW'(i))) begin
                        repend_d[i] = 1'b0;
                        if (repend_q[i] || (mode_q[i] && edge_ev[i]) || (!mode_q[i] && s[i])) begin
                            state_d[i] = SRC_PEND;
                        end else begin
                            state_d[i] = SRC_IDLE;
                        end
                    end
                end
                default: begin
                    state_d[i]  = SRC_IDLE;
                    repend_d[i] = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NSRC; i++) begin
                state_q[i] <= SRC_IDLE;
            end
            repend_q <= '0;
        end else begin
            for (int i = 0; i < NSRC; i++) begin
                state_q[i] <= state_d[i];
            end
            repend_q <= repend_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            enable_q  <= '0;
            mode_q    <= '0;
            gie_q     <= 1'b0;
            interrupt <= 1'b0;
        end else begin
            if (wr_enable) begin
                enable_q <= io_wdata[NSRC-1:0];
            end
            if (wr_mode) begin
                mode_q <= io_wdata[NSRC-1:0];
            end
            if (wr_ctrl) begin
                gie_q <= io_wdata[CTRL_GIE_BIT];
            end
            interrupt <= gie_q && |(pend_vec & enable_q);
        end
    end

    always_comb begin
        io_rdata = '0;
        case (io_addr)
            REG_PENDING: io_rdata[NSRC-1:0] = pend_vec;
            REG_ENABLE:  io_rdata[NSRC-1:0] = enable_q;
            REG_MODE:    io_rdata[NSRC-1:0] = mode_q;
            REG_CLAIM: begin
                if (claim_valid) begin
                    io_rdata[VALID_BIT] = 1'b1;
                    io_rdata[IDW-1:0]   = claim_id;
                end
            end
            REG_CTRL:    io_rdata[CTRL_GIE_BIT] = gie_q;
            default:     io_rdata = '0;
        endcase
    end

endmodule
